// File: rtl/count_timer_pkg.sv
// Shared types and defaults for the interval timer controller and its counter.
// Pure declarations; no logic, no latency.
package count_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PRE_W = 8;

endpackage

// File: rtl/count_en_ctr.sv
// Enable-driven binary counter with synchronous clear (clear wins over enable).
// One-cycle update latency; no backpressure, en/sync_clr are sampled every edge.
module count_en_ctr
    import count_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (sync_clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_timer_ctrl.sv
// Programmable interval timer: start/stop/clear FSM, prescaler, terminal-count done pulse.
// done is registered one cycle after the terminal tick; commands are level-sampled, no backpressure.
module count_timer_ctrl
    import count_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
);

    state_e           state_q,   state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PRE_W-1:0] pre_q,     pre_d;
    logic [WIDTH-1:0] limit_q,   limit_d;
    logic             per_q,     per_d;
    logic             done_q,    done_d;

    logic             tick;
    logic             terminal;
    logic             ctr_en;
    logic             ctr_clr;

    // stop and clear both suppress the tick on their own edge
    assign tick     = (state_q == RUN) && (pre_cnt_q == pre_q) && !stop && !clear;
    assign terminal = tick && (count == limit_q);
    assign ctr_en   = tick && !terminal;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        pre_d     = pre_q;
        limit_d   = limit_q;
        per_d     = per_q;
        done_d    = terminal;
        ctr_clr   = 1'b0;

        if (clear) begin
            state_d   = IDLE;
            pre_cnt_d = '0;
            ctr_clr   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        limit_d   = limit;
                        per_d     = periodic;
                        pre_d     = prescale;
                        pre_cnt_d = '0;
                        ctr_clr   = 1'b1;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = HOLD;
                    end else if (tick) begin
                        pre_cnt_d = '0;
                        if (terminal) begin
                            if (per_q) begin
                                ctr_clr = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (start && !stop) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            pre_q     <= '0;
            limit_q   <= '0;
            per_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            pre_q     <= pre_d;
            limit_q   <= limit_d;
            per_q     <= per_d;
            done_q    <= done_d;
        end
    end

    count_en_ctr #(
        .WIDTH (WIDTH)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .en       (ctr_en),
        .sync_clr (ctr_clr),
        .q        (count)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_count_timer_ctrl.sv
// Directed bench for count_timer_ctrl: one-shot, periodic, pause/resume, priority, limits, async reset.
module tb_count_timer_ctrl;

    localparam int WIDTH = 4;
    localparam int PRE_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic             clear;
    logic             periodic;
    logic [WIDTH-1:0] limit;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state_o;

    int checks = 0;
    int errors = 0;

    count_timer_ctrl #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .periodic (periodic),
        .limit    (limit),
        .prescale (prescale),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        periodic = 1'b0;
        limit    = '0;
        prescale = '0;

        #12;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_o, 0);
        reset = 1'b0;

        // start and stop together in IDLE: stays IDLE
        start = 1'b1; stop = 1'b1;
        cyc();
        chk("idle_ss_state", state_o, 0);
        chk("idle_ss_busy", busy, 0);
        start = 1'b0; stop = 1'b0;

        // one-shot, limit 3, prescale 0
        limit = 4'd3; prescale = 8'd0; periodic = 1'b0; start = 1'b1;
        cyc();
        chk("os_state", state_o, 1);
        chk("os_count0", count, 0);
        chk("os_busy", busy, 1);
        start = 1'b0; limit = 4'd7;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("os_count", count, i);
            chk("os_done_lo", done, 0);
        end
        cyc();
        chk("os_done_hi", done, 1);
        chk("os_busy_end", busy, 0);
        chk("os_count_hold", count, 3);
        cyc();
        chk("os_done_pulse", done, 0);
        chk("os_count_idle", count, 3);

        // periodic, limit 2, prescale 1: count steps every 2 cycles, done every 6
        limit = 4'd2; prescale = 8'd1; periodic = 1'b1; start = 1'b1;
        cyc();
        chk("per_count0", count, 0);
        start = 1'b0; limit = 4'd0; prescale = 8'd0;
        for (int e = 1; e <= 17; e++) begin
            cyc();
            chk("per_count", count, (e / 2) % 3);
            chk("per_done", done, (e % 6 == 0) ? 1 : 0);
            chk("per_busy", busy, 1);
        end
        // clear lands on what would be a terminal edge: pulse is discarded
        clear = 1'b1;
        cyc();
        chk("clr_state", state_o, 0);
        chk("clr_count", count, 0);
        chk("clr_done", done, 0);
        clear = 1'b0;

        // pause/resume, one-shot limit 5
        limit = 4'd5; prescale = 8'd0; periodic = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("pr_count2", count, 2);
        stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("pr_hold_state", state_o, 2);
            chk("pr_hold_count", count, 2);
        end
        start = 1'b1;
        cyc();
        chk("hold_ss_state", state_o, 2);
        stop = 1'b0;
        cyc();
        chk("pr_resume_state", state_o, 1);
        chk("pr_resume_count", count, 2);
        start = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            cyc();
            chk("pr_count", count, i);
        end
        cyc();
        chk("pr_done", done, 1);
        chk("pr_state_end", state_o, 0);
        chk("pr_count_end", count, 5);

        // clear + stop + start together in RUN
        limit = 4'd5; prescale = 8'd0; periodic = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("prio_pre_count", count, 2);
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        cyc();
        chk("prio_state", state_o, 0);
        chk("prio_count", count, 0);
        chk("prio_done", done, 0);
        chk("prio_busy", busy, 0);
        clear = 1'b0; stop = 1'b0; start = 1'b0;

        // limit 0 periodic: every tick terminal
        limit = 4'd0; prescale = 8'd0; periodic = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("lim0_done", done, 1);
            chk("lim0_count", count, 0);
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;

        // limit 15 periodic: reaches all-ones then reloads
        limit = 4'd15; prescale = 8'd0; periodic = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (14) cyc();
        cyc();
        chk("lim15_count", count, 15);
        chk("lim15_done_lo", done, 0);
        cyc();
        chk("lim15_wrap", count, 0);
        chk("lim15_done", done, 1);
        chk("lim15_state", state_o, 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;

        // async reset mid-RUN
        limit = 4'd9; prescale = 8'd0; periodic = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        chk("ar_pre_count", count, 3);
        #2 reset = 1'b1;
        #1;
        chk("ar_count", count, 0);
        chk("ar_busy", busy, 0);
        chk("ar_state", state_o, 0);
        chk("ar_done", done, 0);
        cyc();
        #3 reset = 1'b0;
        repeat (3) cyc();
        chk("ar_idle_count", count, 0);
        chk("ar_idle_state", state_o, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("ar_restart_count", count, 1);
        chk("ar_restart_state", state_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
